// File: rtl/tx_video_fifo_drain.sv
// Purpose: polls the tx_video FIFO fill level over CSR, prefetches bytes into a small local buffer, paces them to the DAC.
// Latency: first FIFO byte reaches dac_data no earlier than 3+RD_LATENCY cycles after enable rises; one byte per DIV-cycle tick.
// Backpressure: reads are issued only while space = LBUF_DEPTH - count - inflight > 0; an empty buffer on a tick emits IDLE_CODE.
module tx_video_fifo_drain #(
    parameter int          DIV        = 4,
    parameter int          LBUF_DEPTH = 4,
    parameter int          RD_LATENCY = 1,
    parameter int          POLL_GAP   = 8,
    parameter logic [7:0]  IDLE_CODE  = 8'h80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [2:0]  csr_address,
    output logic        csr_read,
    output logic        csr_write,
    output logic [31:0] csr_writedata,
    input  logic [31:0] csr_readdata,
    output logic        rd_read,
    input  logic [7:0]  rd_readdata,
    output logic [7:0]  dac_data,
    output logic        dac_strobe,
    output logic [15:0] underrun_count,
    output logic        busy
);

    localparam int AW = (LBUF_DEPTH > 1) ? $clog2(LBUF_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW = $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_POLL_WAIT,
        S_GAP,
        S_FETCH
    } state_t;

    state_t                state_q;
    logic [15:0]           credits_q;
    logic [GW-1:0]         gap_cnt_q;
    logic                  csr_read_q;
    logic                  rd_read_q;
    logic [RD_LATENCY-1:0] rd_pipe_q;
    logic [CW-1:0]         inflight_q;
    logic [CW-1:0]         inflight_d;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [7:0]            buf_q [LBUF_DEPTH];
    logic [TW-1:0]         tick_cnt_q;
    logic [7:0]            dac_data_q;
    logic                  dac_strobe_q;
    logic [15:0]           underrun_q;

    logic [CW-1:0]         space;
    logic                  issue;
    logic                  push;
    logic                  tick;
    logic                  pop;

    // Fixed CSR side: only ever reads the fill_level register.
    assign csr_address    = 3'd0;
    assign csr_write      = 1'b0;
    assign csr_writedata  = 32'd0;
    assign csr_read       = csr_read_q;
    assign rd_read        = rd_read_q;
    assign dac_data       = dac_data_q;
    assign dac_strobe     = dac_strobe_q;
    assign underrun_count = underrun_q;
    assign busy           = (state_q != S_IDLE) || (inflight_q != '0);

    // Space counts outstanding reads as occupied so a returning byte always finds a free slot.
    always_comb begin
        space = CW'(LBUF_DEPTH) - count_q - inflight_q;
        issue = (state_q == S_FETCH) && enable && (credits_q != 16'd0) && (space != '0);
        push  = rd_pipe_q[RD_LATENCY-1];
        tick  = enable && (tick_cnt_q == TW'(DIV - 1));
        pop   = tick && (count_q != '0);
    end

    // Next-state occupancy of the read pipe and the local buffer.
    always_comb begin
        inflight_d = inflight_q;
        if (issue && !push) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!issue && push) begin
            inflight_d = inflight_q - CW'(1);
        end
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control FSM: poll fill level, wait out empty polls, fetch against credits, drain before idling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            credits_q  <= 16'd0;
            gap_cnt_q  <= '0;
            csr_read_q <= 1'b0;
        end else begin
            csr_read_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q    <= S_POLL;
                        csr_read_q <= 1'b1;
                    end
                end
                S_POLL: begin
                    state_q <= enable ? S_POLL_WAIT : S_IDLE;
                end
                S_POLL_WAIT: begin
                    // Fill levels beyond 16 bits saturate; we only ever need "plenty".
                    credits_q <= (csr_readdata[31:16] != 16'd0) ? 16'hFFFF : csr_readdata[15:0];
                    if (!enable) begin
                        state_q <= S_IDLE;
                    end else if (csr_readdata != 32'd0) begin
                        state_q <= S_FETCH;
                    end else begin
                        state_q   <= S_GAP;
                        gap_cnt_q <= '0;
                    end
                end
                S_GAP: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                    end else if (gap_cnt_q == GW'(POLL_GAP - 1)) begin
                        state_q    <= S_POLL;
                        csr_read_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                S_FETCH: begin
                    if (issue) begin
                        credits_q <= credits_q - 16'd1;
                    end
                    // Leave only once every issued byte has landed in the buffer.
                    if (!enable) begin
                        if (inflight_d == '0) begin
                            state_q <= S_IDLE;
                        end
                    end else if ((credits_q == 16'd0) && (inflight_d == '0)) begin
                        state_q    <= S_POLL;
                        csr_read_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Read strobe plus a delay line that marks when each requested byte arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_read_q  <= 1'b0;
            rd_pipe_q  <= '0;
            inflight_q <= '0;
        end else begin
            rd_read_q    <= issue;
            rd_pipe_q[0] <= rd_read_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
            inflight_q <= inflight_d;
        end
    end

    // Local prefetch buffer: strict FIFO ring.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < LBUF_DEPTH; i++) begin
                buf_q[i] <= 8'd0;
            end
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= rd_readdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Sample tick divider; parked at zero while disabled so the phase restarts cleanly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else if (!enable || (tick_cnt_q == TW'(DIV - 1))) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
        end
    end

    // DAC output: oldest byte on each tick, or the idle code plus an underrun count when starved.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dac_data_q   <= IDLE_CODE;
            dac_strobe_q <= 1'b0;
            underrun_q   <= 16'd0;
        end else begin
            dac_strobe_q <= tick;
            if (tick) begin
                if (count_q != '0) begin
                    dac_data_q <= buf_q[rd_ptr_q];
                end else begin
                    dac_data_q <= IDLE_CODE;
                    if (underrun_q != 16'hFFFF) begin
                        underrun_q <= underrun_q + 16'd1;
                    end
                end
            end
        end
    end

    // A push into a full buffer would mean the space accounting is broken.
    assert property (@(posedge clk) disable iff (!reset_n) push |-> (count_q < CW'(LBUF_DEPTH)));

endmodule

// File: tb/tb_tx_video_fifo_drain.sv
// Directed bench for tx_video_fifo_drain with a behavioural model of the upstream FIFO.
// Model answers CSR polls one cycle late and returns bytes RD_LATENCY cycles after each read.
// Strobes are logged and compared with hand-derived sequences.
module tb_tx_video_fifo_drain;

    localparam int DIV  = 4;
    localparam int LBUF = 4;
    localparam int RDL  = 2;
    localparam int PG   = 8;

    logic        clk          = 1'b0;
    logic        reset_n      = 1'b0;
    logic        enable       = 1'b0;
    logic [2:0]  csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata = 32'hBAD0_BAD0;
    logic        rd_read;
    logic [7:0]  rd_readdata  = 8'hEE;
    logic [7:0]  dac_data;
    logic        dac_strobe;
    logic [15:0] underrun_count;
    logic        busy;

    tx_video_fifo_drain #(
        .DIV(DIV), .LBUF_DEPTH(LBUF), .RD_LATENCY(RDL), .POLL_GAP(PG), .IDLE_CODE(8'h80)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .rd_read(rd_read), .rd_readdata(rd_readdata),
        .dac_data(dac_data), .dac_strobe(dac_strobe),
        .underrun_count(underrun_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Upstream FIFO model and output monitor
    logic [7:0]  fifo_q [$];
    logic        csr_pend = 1'b0;
    logic        pipe_v [0:RDL];
    logic [7:0]  pipe_d [0:RDL];
    int          cyc = 0;
    int          rd_cnt = 0;
    int          csr_cnt = 0;
    int          underflow = 0;
    int          idle_bad = 0;
    int          max_out = 0;
    int          csr_t [$];
    int          str_t [$];
    logic [7:0]  all_d [$];
    logic [15:0] all_u [$];
    logic [7:0]  data_log [$];
    logic [15:0] last_ur = 16'd0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            csr_pend = 1'b0;
            for (int k = 0; k <= RDL; k++) begin
                pipe_v[k] = 1'b0;
                pipe_d[k] = 8'hEE;
            end
            csr_readdata = 32'hBAD0_BAD0;
            rd_readdata  = 8'hEE;
        end else begin
            csr_readdata = csr_pend ? 32'(fifo_q.size()) : 32'hBAD0_BAD0;
            csr_pend = csr_read;
            if (csr_read) begin
                csr_cnt++;
                csr_t.push_back(cyc);
            end
            for (int k = RDL; k > 0; k--) begin
                pipe_v[k] = pipe_v[k-1];
                pipe_d[k] = pipe_d[k-1];
            end
            pipe_v[0] = rd_read;
            pipe_d[0] = 8'hEE;
            if (rd_read) begin
                rd_cnt++;
                if (fifo_q.size() == 0) underflow++;
                else pipe_d[0] = fifo_q.pop_front();
            end
            rd_readdata = pipe_v[RDL] ? pipe_d[RDL] : 8'hEE;
            if (dac_strobe) begin
                str_t.push_back(cyc);
                all_d.push_back(dac_data);
                all_u.push_back(underrun_count);
                if (underrun_count != last_ur) begin
                    if (dac_data != 8'h80) idle_bad++;
                    last_ur = underrun_count;
                end else begin
                    data_log.push_back(dac_data);
                end
            end
            if (rd_cnt - data_log.size() > max_out) max_out = rd_cnt - data_log.size();
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        reset_n = 1'b0;
        fifo_q.delete();
        csr_t.delete(); str_t.delete(); all_d.delete(); all_u.delete(); data_log.delete();
        rd_cnt = 0; csr_cnt = 0; max_out = 0; last_ur = 16'd0;
        step(3);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic wait_strobes(input string tag, input int n, input int bound);
        int k = 0;
        while (all_d.size() < n && k < bound) begin
            step(1);
            k++;
        end
        chk(tag, 32'(all_d.size() >= n), 32'd1);
    endtask

    task automatic wait_data(input string tag, input int n, input int bound);
        int k = 0;
        while (data_log.size() < n && k < bound) begin
            step(1);
            k++;
        end
        chk(tag, 32'(data_log.size() >= n), 32'd1);
    endtask

    task automatic wait_reads(input string tag, input int n, input int bound);
        int k = 0;
        while (rd_cnt < n && k < bound) begin
            step(1);
            k++;
        end
        chk(tag, 32'(rd_cnt >= n), 32'd1);
    endtask

    logic [7:0]  e2_d [6] = '{8'h80, 8'h11, 8'h22, 8'h33, 8'h80, 8'h80};
    logic [15:0] e2_u [6] = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3};
    logic [15:0] e6_u [5] = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

    initial begin
        // Reset state
        step(2);
        chk("rst_dac_data", 32'(dac_data), 32'h80);
        chk("rst_strobe", 32'(dac_strobe), 32'd0);
        chk("rst_rd_read", 32'(rd_read), 32'd0);
        chk("rst_csr_read", 32'(csr_read), 32'd0);
        chk("rst_underrun", 32'(underrun_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("csr_write", 32'(csr_write), 32'd0);
        chk("csr_addr_wdata", 32'(csr_address) | csr_writedata, 32'd0);

        // Fill of three bytes: one idle tick before data, then 11,22,33, then underruns
        do_reset();
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
        enable = 1'b1;
        wait_strobes("t2_strobes", 6, 100);
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t2_data%0d", i), 32'(all_d[i]), 32'(e2_d[i]));
            chk($sformatf("t2_ur%0d", i), 32'(all_u[i]), 32'(e2_u[i]));
            if (i > 0) chk($sformatf("t2_gap%0d", i), 32'(str_t[i] - str_t[i-1]), 32'(DIV));
        end
        chk("t2_reads", 32'(rd_cnt), 32'd3);
        chk("t2_first_csr_before_data", 32'(csr_t[0] + 3 + RDL <= str_t[1]), 32'd1);

        // Empty FIFO: polls spaced POLL_GAP+2, never a data read
        do_reset();
        enable = 1'b1;
        step(60);
        enable = 1'b0;
        chk("t5_polls", 32'(csr_t.size() >= 5), 32'd1);
        for (int i = 1; i < 5 && i < csr_t.size(); i++)
            chk($sformatf("t5_spacing%0d", i), 32'(csr_t[i] - csr_t[i-1]), 32'(PG + 2));
        chk("t5_no_reads", 32'(rd_cnt), 32'd0);

        // Fill of 100: in order, never more than LBUF prefetched, no underrun once flowing
        do_reset();
        for (int i = 0; i < 100; i++) fifo_q.push_back(8'(i + 1));
        enable = 1'b1;
        wait_data("t3_done", 100, 800);
        enable = 1'b0;
        for (int i = 0; i < 100 && i < data_log.size(); i++)
            chk($sformatf("t3_byte%0d", i), 32'(data_log[i]), 32'(i + 1));
        chk("t3_max_outstanding", 32'(max_out <= LBUF), 32'd1);
        chk("t3_underrun_steady", 32'(last_ur), 32'd1);

        // Disable in mid-fetch with two reads outstanding
        do_reset();
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'hA0 + 8'(i));
        enable = 1'b1;
        wait_reads("t4_two_reads", 2, 50);
        enable = 1'b0;
        step(1);
        chk("t4_no_rd_next", 32'(rd_read), 32'd0);
        chk("t4_busy_c1", 32'(busy), 32'd1);
        step(1);
        chk("t4_busy_c2", 32'(busy), 32'd1);
        step(1);
        chk("t4_busy_fall", 32'(busy), 32'd0);
        step(8);
        chk("t4_reads_total", 32'(rd_cnt), 32'd2);
        chk("t4_no_strobe_off", 32'(all_d.size()), 32'd1);
        chk("t4_dac_hold", 32'(dac_data), 32'h80);
        enable = 1'b1;
        wait_data("t4_resume", 10, 300);
        enable = 1'b0;
        for (int i = 0; i < 10 && i < data_log.size(); i++)
            chk($sformatf("t4_byte%0d", i), 32'(data_log[i]), 32'(8'hA0 + 8'(i)));

        // Asynchronous reset mid-burst
        do_reset();
        for (int i = 0; i < 20; i++) fifo_q.push_back(8'h40 + 8'(i));
        enable = 1'b1;
        wait_reads("t1_burst", 3, 50);
        chk("t1_busy_before", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t1_dac_data", 32'(dac_data), 32'h80);
        chk("t1_strobe", 32'(dac_strobe), 32'd0);
        chk("t1_rd_read", 32'(rd_read), 32'd0);
        chk("t1_csr_read", 32'(csr_read), 32'd0);
        chk("t1_underrun", 32'(underrun_count), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        enable = 1'b0;

        // Saturating underrun counter
        do_reset();
        force dut.underrun_q = 16'hFFFD;
        #1;
        release dut.underrun_q;
        step(1);
        chk("t6_preset", 32'(underrun_count), 32'hFFFD);
        enable = 1'b1;
        wait_strobes("t6_strobes", 5, 100);
        enable = 1'b0;
        for (int i = 0; i < 5 && i < all_d.size(); i++) begin
            chk($sformatf("t6_ur%0d", i), 32'(all_u[i]), 32'(e6_u[i]));
            chk($sformatf("t6_data%0d", i), 32'(all_d[i]), 32'h80);
        end

        chk("model_underflow", 32'(underflow), 32'd0);
        chk("idle_code_on_underrun", 32'(idle_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
